// File: rtl/cat_trap_game_ctrl.sv
// -----------------------------------------------------------------------------
// cat_trap_game_ctrl
//
// Game sequencer for the 8x8 cat-trap board. Holds the 2-bit-per-cell board
// memory, the player cursor and the cat position. It turns debounced button
// pulses into wall placements, then spends one cycle per neighbour searching
// for a free cell for the cat. The game is won when the cat is boxed in and
// lost when the cat reaches the border.
//
// Ports:
//   clk, reset_n           slow game clock, asynchronous active-low reset
//   btn_up/down/left/right single-cycle pulses that move the cursor (PLAY only)
//   btn_center             single-cycle pulse: start a game or place a wall
//   rd_row, rd_col         renderer read address
//   rd_cell                board cell at the read address (0 empty, 1 wall, 2 cat),
//                          combinational
//   cursor_row, cursor_col current cursor position
//   cat_row, cat_col       current cat position
//   game_state             0 START, 1 INIT, 2 PLAY, 3 CHECK, 4 WIN, 5 LOSE
//   move_count             walls placed in the current game (saturating)
//   busy                   high while clearing the board or searching for a cat move
// -----------------------------------------------------------------------------
module cat_trap_game_ctrl #(
    parameter int CAT_ROW   = 3,
    parameter int CAT_COL   = 3,
    parameter int MAX_MOVES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell,
    output logic [2:0] cursor_row,
    output logic [2:0] cursor_col,
    output logic [2:0] cat_row,
    output logic [2:0] cat_col,
    output logic [2:0] game_state,
    output logic [7:0] move_count,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_INIT  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_WALL  = 2'd1;
    localparam logic [1:0] CELL_CAT   = 2'd2;

    localparam logic [2:0] CAT_ROW_INIT = 3'(CAT_ROW);
    localparam logic [2:0] CAT_COL_INIT = 3'(CAT_COL);
    localparam logic [7:0] MOVES_MAX    = 8'(MAX_MOVES);

    state_t     state_q, state_d;
    logic [1:0] board_q [64];
    logic [1:0] board_d [64];
    logic [5:0] clear_idx_q, clear_idx_d;
    logic       clear_done_q, clear_done_d;
    logic [2:0] cursor_row_q, cursor_row_d;
    logic [2:0] cursor_col_q, cursor_col_d;
    logic [2:0] cat_row_q, cat_row_d;
    logic [2:0] cat_col_q, cat_col_d;
    logic [7:0] move_count_q, move_count_d;
    logic [1:0] nbr_idx_q, nbr_idx_d;

    logic [5:0] cursor_idx;
    logic [5:0] cat_idx;
    logic [5:0] cand_idx;
    logic [2:0] cand_row;
    logic [2:0] cand_col;
    logic       cand_is_wall;
    logic       cand_on_edge;
    logic       place_ok;

    // Addresses are {row, col}, so the board is laid out row-major.
    assign cursor_idx = {cursor_row_q, cursor_col_q};
    assign cat_idx    = {cat_row_q, cat_col_q};
    assign cand_idx   = {cand_row, cand_col};
    assign rd_cell    = board_q[{rd_row, rd_col}];

    // Candidate cell for the cat, picked by the neighbour index in the fixed
    // order down, up, right, left. The cat is interior whenever this is used,
    // so the 3-bit arithmetic never wraps in practice.
    always_comb begin
        cand_row = cat_row_q;
        cand_col = cat_col_q;
        case (nbr_idx_q)
            2'd0:    cand_row = cat_row_q + 3'd1;
            2'd1:    cand_row = cat_row_q - 3'd1;
            2'd2:    cand_col = cat_col_q + 3'd1;
            default: cand_col = cat_col_q - 3'd1;
        endcase
        cand_is_wall = (board_q[cand_idx] == CELL_WALL);
        cand_on_edge = (cand_row == 3'd0) || (cand_row == 3'd7) ||
                       (cand_col == 3'd0) || (cand_col == 3'd7);
        place_ok     = btn_center && (board_q[cursor_idx] == CELL_EMPTY);
    end

    // State register; reset aborts any clear or search in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (btn_center) state_d = ST_INIT;
            ST_INIT:  if (clear_done_q) state_d = ST_PLAY;
            ST_PLAY:  if (place_ok) state_d = ST_CHECK;
            ST_CHECK: begin
                if (!cand_is_wall) begin
                    state_d = cand_on_edge ? ST_LOSE : ST_PLAY;
                end else if (nbr_idx_q == 2'd3) begin
                    state_d = ST_WIN;
                end
            end
            ST_WIN, ST_LOSE: if (btn_center) state_d = ST_INIT;
            default: state_d = ST_START;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        game_state = state_q;
        busy       = (state_q == ST_INIT) || (state_q == ST_CHECK);
    end

    // Datapath next values: board writes, cursor movement, cat moves and the
    // wall counter. The board needs two write ports in CHECK because the cat
    // leaves its old cell and lands on the new one at the same edge.
    always_comb begin
        board_d      = board_q;
        clear_idx_d  = clear_idx_q;
        clear_done_d = clear_done_q;
        cursor_row_d = cursor_row_q;
        cursor_col_d = cursor_col_q;
        cat_row_d    = cat_row_q;
        cat_col_d    = cat_col_q;
        move_count_d = move_count_q;
        nbr_idx_d    = nbr_idx_q;
        case (state_q)
            ST_START, ST_WIN, ST_LOSE: begin
                if (btn_center) begin
                    clear_idx_d  = 6'd0;
                    clear_done_d = 1'b0;
                end
            end
            ST_INIT: begin
                // 64 clearing edges, then one edge that drops the cat in.
                if (!clear_done_q) begin
                    board_d[clear_idx_q] = CELL_EMPTY;
                    clear_idx_d          = clear_idx_q + 6'd1;
                    clear_done_d         = (clear_idx_q == 6'd63);
                end else begin
                    board_d[{CAT_ROW_INIT, CAT_COL_INIT}] = CELL_CAT;
                    cat_row_d    = CAT_ROW_INIT;
                    cat_col_d    = CAT_COL_INIT;
                    move_count_d = 8'd0;
                end
            end
            ST_PLAY: begin
                // Center wins over any direction pulse in the same cycle.
                if (btn_center) begin
                    if (place_ok) begin
                        board_d[cursor_idx] = CELL_WALL;
                        nbr_idx_d           = 2'd0;
                        if (move_count_q < MOVES_MAX) begin
                            move_count_d = move_count_q + 8'd1;
                        end
                    end
                end else begin
                    if (btn_up && !btn_down) cursor_row_d = cursor_row_q - 3'd1;
                    if (btn_down && !btn_up) cursor_row_d = cursor_row_q + 3'd1;
                    if (btn_left && !btn_right) cursor_col_d = cursor_col_q - 3'd1;
                    if (btn_right && !btn_left) cursor_col_d = cursor_col_q + 3'd1;
                end
            end
            ST_CHECK: begin
                if (!cand_is_wall) begin
                    board_d[cat_idx]  = CELL_EMPTY;
                    board_d[cand_idx] = CELL_CAT;
                    cat_row_d         = cand_row;
                    cat_col_d         = cand_col;
                end else if (nbr_idx_q != 2'd3) begin
                    nbr_idx_d = nbr_idx_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                board_q[i] <= CELL_EMPTY;
            end
            clear_idx_q  <= 6'd0;
            clear_done_q <= 1'b0;
            cursor_row_q <= 3'd0;
            cursor_col_q <= 3'd0;
            cat_row_q    <= CAT_ROW_INIT;
            cat_col_q    <= CAT_COL_INIT;
            move_count_q <= 8'd0;
            nbr_idx_q    <= 2'd0;
        end else begin
            board_q      <= board_d;
            clear_idx_q  <= clear_idx_d;
            clear_done_q <= clear_done_d;
            cursor_row_q <= cursor_row_d;
            cursor_col_q <= cursor_col_d;
            cat_row_q    <= cat_row_d;
            cat_col_q    <= cat_col_d;
            move_count_q <= move_count_d;
            nbr_idx_q    <= nbr_idx_d;
        end
    end

    assign cursor_row = cursor_row_q;
    assign cursor_col = cursor_col_q;
    assign cat_row    = cat_row_q;
    assign cat_col    = cat_col_q;
    assign move_count = move_count_q;

endmodule

// File: tb/tb_cat_trap_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cat_trap_game_ctrl
//
// Self-checking bench for cat_trap_game_ctrl. A behavioural model of the game
// predicts the outcome of every center press (new game or wall placement) and
// pushes it to a scoreboard; the entry is popped and compared once the DUT
// drops busy. Cursor and board contents are compared against the model too.
// -----------------------------------------------------------------------------
module tb_cat_trap_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_center = 1'b0;
    logic [2:0] rd_row = 3'd0;
    logic [2:0] rd_col = 3'd0;
    logic [1:0] rd_cell;
    logic [2:0] cursor_row;
    logic [2:0] cursor_col;
    logic [2:0] cat_row;
    logic [2:0] cat_col;
    logic [2:0] game_state;
    logic [7:0] move_count;
    logic       busy;

    cat_trap_game_ctrl #(
        .CAT_ROW  (3),
        .CAT_COL  (3),
        .MAX_MOVES(255)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_cell   (rd_cell),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .cat_row   (cat_row),
        .cat_col   (cat_col),
        .game_state(game_state),
        .move_count(move_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state;
        int cat_row;
        int cat_col;
        int moves;
        int cycles;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the game.
    int m_board[64];
    int m_cat_row, m_cat_col, m_cur_row, m_cur_col, m_state, m_moves;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_board[i] = 0;
        m_cat_row = 3;
        m_cat_col = 3;
        m_cur_row = 0;
        m_cur_col = 0;
        m_state   = 0;
        m_moves   = 0;
    endtask

    // Predicts the effect of a center press and queues the expected outcome.
    task automatic model_center();
        exp_t e;
        int   cycles;
        int   r, c, idx;
        bit   trapped;
        cycles = 0;
        if (m_state == 0 || m_state == 4 || m_state == 5) begin
            for (int i = 0; i < 64; i++) m_board[i] = 0;
            m_board[3*8+3] = 2;
            m_cat_row = 3;
            m_cat_col = 3;
            m_moves   = 0;
            m_state   = 2;
            cycles    = 65;
        end else if (m_state == 2) begin
            idx = m_cur_row * 8 + m_cur_col;
            if (m_board[idx] == 0) begin
                m_board[idx] = 1;
                if (m_moves < 255) m_moves++;
                trapped = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    r = m_cat_row;
                    c = m_cat_col;
                    case (i)
                        0: r = r + 1;
                        1: r = r - 1;
                        2: c = c + 1;
                        default: c = c - 1;
                    endcase
                    cycles = i + 1;
                    if (m_board[r*8+c] != 1) begin
                        m_board[m_cat_row*8+m_cat_col] = 0;
                        m_board[r*8+c] = 2;
                        m_cat_row = r;
                        m_cat_col = c;
                        m_state = (r == 0 || r == 7 || c == 0 || c == 7) ? 5 : 2;
                        trapped = 1'b0;
                        break;
                    end
                end
                if (trapped) m_state = 4;
            end
        end
        e.state   = m_state;
        e.cat_row = m_cat_row;
        e.cat_col = m_cat_col;
        e.moves   = m_moves;
        e.cycles  = cycles;
        sb_q.push_back(e);
    endtask

    // Drives one pulse for one clock edge, updates the model, checks the cursor.
    task automatic applyStimulus(input logic up, input logic down, input logic left,
                                 input logic right, input logic center);
        @(negedge clk);
        btn_up     = up;
        btn_down   = down;
        btn_left   = left;
        btn_right  = right;
        btn_center = center;
        if (center) begin
            model_center();
        end else if (m_state == 2) begin
            if (up && !down) m_cur_row = (m_cur_row + 7) % 8;
            if (down && !up) m_cur_row = (m_cur_row + 1) % 8;
            if (left && !right) m_cur_col = (m_cur_col + 7) % 8;
            if (right && !left) m_cur_col = (m_cur_col + 1) % 8;
        end
        @(posedge clk);
        #1;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_center = 1'b0;
        checkOutput("cursor_row", cursor_row, m_cur_row);
        checkOutput("cursor_col", cursor_col, m_cur_col);
    endtask

    // Waits (bounded) for busy to fall, then pops and compares the prediction.
    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({tag, "_busy_cycles"}, n, e.cycles);
            checkOutput({tag, "_state"}, game_state, e.state);
            checkOutput({tag, "_cat_row"}, cat_row, e.cat_row);
            checkOutput({tag, "_cat_col"}, cat_col, e.cat_col);
            checkOutput({tag, "_moves"}, move_count, e.moves);
        end
    endtask

    task automatic compare_board(input string tag);
        for (int i = 0; i < 64; i++) begin
            rd_row = 3'(i / 8);
            rd_col = 3'(i % 8);
            #1;
            checkOutput($sformatf("%s[%0d]", tag, i), rd_cell, m_board[i]);
        end
    endtask

    task automatic move_cursor_to(input int r, input int c);
        while (m_cur_row != r || m_cur_col != c) begin
            applyStimulus(1'b0, m_cur_row != r, 1'b0, m_cur_col != c, 1'b0);
        end
    endtask

    task automatic place(input int r, input int c, input string tag);
        move_cursor_to(r, c);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(tag);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_state"}, game_state, 0);
        checkOutput({tag, "_cursor_row"}, cursor_row, 0);
        checkOutput({tag, "_cursor_col"}, cursor_col, 0);
        checkOutput({tag, "_cat_row"}, cat_row, 3);
        checkOutput({tag, "_cat_col"}, cat_col, 3);
        checkOutput({tag, "_moves"}, move_count, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        compare_board("reset_board");
        @(negedge clk);
        reset_n = 1'b1;

        // Direction pulse in START is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_hold_state", game_state, 0);

        // New game: 65 INIT cycles, then PLAY with the cat placed.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("init");
        rd_row = 3'd3;
        rd_col = 3'd3;
        #1;
        checkOutput("init_cat_cell", rd_cell, 2);

        // Cursor wrap and cancellation.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Center on the cat cell (with a direction pulse) does nothing.
        move_cursor_to(3, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("illegal_cat");
        compare_board("illegal_cat_board");

        // Escape: first placement also checks the read-old-before-edge behaviour.
        move_cursor_to(0, 0);
        @(negedge clk);
        rd_row     = 3'd0;
        rd_col     = 3'd0;
        btn_center = 1'b1;
        model_center();
        #3;
        checkOutput("rd_before_write", rd_cell, 0);
        @(posedge clk);
        #1;
        btn_center = 1'b0;
        checkOutput("rd_after_write", rd_cell, 1);
        wait_done("escape1");

        // Center on an existing wall does nothing.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("illegal_wall");

        place(0, 1, "escape2");
        place(0, 2, "escape3");
        place(0, 4, "escape4");
        compare_board("lose_board");

        // Directions ignored in LOSE, then center restarts.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("regame_from_lose");
        compare_board("regame_board");

        // Trap the cat.
        place(5, 3, "trap1");
        place(2, 3, "trap2");
        place(3, 4, "trap3");
        place(3, 2, "trap4");
        place(4, 3, "trap5");
        compare_board("win_board");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("regame_from_win");
        compare_board("regame2_board");

        // Abort during the long CHECK of the trapping placement.
        place(5, 3, "abort1");
        place(2, 3, "abort2");
        place(3, 4, "abort3");
        place(3, 2, "abort4");
        move_cursor_to(4, 3);
        @(negedge clk);
        btn_center = 1'b1;
        @(posedge clk);
        #1;
        btn_center = 1'b0;
        checkOutput("abort_in_check", game_state, 3);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("abort");
        compare_board("abort_board");
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("sb_leftover", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cat_trap_game_ctrl.md
Name: cat_trap_game_ctrl

Overview:
- Game sequencer for the 8x8 cat-trap board.
- Owns the board-state memory (2 bits per cell), the player cursor, and the cat position.
- Turns debounced button pulses into wall placements, then runs the cat-move search over several cycles and decides win or loss.
- The VGA renderer reads cells through a combinational read port and reads `game_state` to pick the background colour.

Parameters:
- CAT_ROW, 3, cat start row; legal range 1..6 (interior only).
- CAT_COL, 3, cat start column; legal range 1..6.
- MAX_MOVES, 255, saturation value of `move_count`; must be at most 255.

Ports:
- clk  in  1  system clock (slow game clock).
- reset_n  in  1  reset, asynchronous, active-low.
- btn_up / btn_down / btn_left / btn_right  in  1 each  single-cycle debounced pulses; move the cursor.
- btn_center  in  1  single-cycle debounced pulse; start a game or place a wall.
- rd_row, rd_col  in  3 each  renderer read address.
- rd_cell  out  2  board cell at (rd_row, rd_col), combinational; 0 = empty, 1 = wall, 2 = cat.
- cursor_row, cursor_col  out  3 each  current cursor position.
- cat_row, cat_col  out  3 each  current cat position.
- game_state  out  3  0 = START, 1 = INIT, 2 = PLAY, 3 = CHECK, 4 = WIN, 5 = LOSE.
- move_count  out  8  walls placed in the current game.
- busy  out  1  high in INIT and CHECK.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state START; all 64 cells = 0; cursor (0,0); cat (CAT_ROW, CAT_COL); move_count 0; nbr_idx 0; busy 0.
  - Reset asserted mid-INIT or mid-CHECK aborts immediately to these values.
- START:
  - btn_center → INIT at that edge.
  - Direction buttons are ignored.
- INIT:
  - Edges 1..64 after entry clear cells 0..63 in row-major order; clear_idx is 6 bits.
  - Edge 65 writes 2 at (CAT_ROW, CAT_COL), loads the cat position, clears move_count, and enters PLAY.
  - All buttons are ignored during INIT.
- PLAY, cursor:
  - btn_up decrements cursor_row; btn_down increments it; btn_left / btn_right decrement / increment cursor_col.
  - All cursor arithmetic is modulo 8, so 7+1 wraps to 0 and 0-1 wraps to 7.
  - Up and down pressed together cancel; left and right together cancel. Row and column update independently in the same cycle.
- PLAY, btn_center:
  - Center has priority: when it is pressed, direction pulses in the same cycle are ignored.
  - If the cursor cell is 0: write 1 to it, increment move_count (saturating at MAX_MOVES), set nbr_idx = 0, and enter CHECK.
  - If the cursor cell is 1 or 2: no effect.
- CHECK examines one neighbour per edge, in fixed priority:
  - nbr_idx 0 = down (row+1), 1 = up (row-1), 2 = right (col+1), 3 = left (col-1).
  - If the candidate cell is not 1: write 2 to the candidate, write 0 to the old cat cell, and update cat_row / cat_col, all at the same edge. Then, if the new row or column is 0 or 7, go to LOSE; otherwise go to PLAY.
  - If the candidate is 1 and nbr_idx < 3: increment nbr_idx.
  - If the candidate is 1 and nbr_idx == 3: go to WIN; the cat does not move.
  - Latency from the center edge to PLAY / LOSE / WIN is 1–4 cycles.
  - The cat is always interior while in CHECK, so candidates never fall off the board.
  - All buttons are ignored during CHECK.
- WIN / LOSE:
  - Board, cat, and move_count are held for display.
  - btn_center → INIT; direction buttons are ignored.
- rd_cell has no read latency.
- Board writes and the rd_cell read of the same cell in the same cycle: rd_cell shows the old value until the edge.

Test Plan:
1. Reset → game_state=0, cursor (0,0), cat (3,3), move_count=0, rd_cell=0 for all 64 addresses. Then btn_center → game_state=1 for 65 cycles, then 2; rd_cell(3,3)=2.
2. Cursor: from (0,0), btn_up → cursor_row=7; btn_left → cursor_col=7; btn_up and btn_down in the same cycle → row unchanged; a direction pulse in START → ignored.
3. Escape: place walls at (0,0), (0,1), (0,2), (0,4).
   - Cat goes (4,3), (5,3), (6,3), (7,3); each CHECK lasts 1 cycle.
   - After the 4th placement, game_state=5 and move_count=4.
4. Trap: place walls at (5,3), (2,3), (3,4), (3,2), (4,3).
   - Cat path (4,3), (3,3), (4,3), (3,3).
   - The 5th placement holds CHECK for 4 cycles, then game_state=4, cat stays (3,3), move_count=5.
5. Illegal select: btn_center with the cursor on the cat cell or on an existing wall → no board change, move_count unchanged, stays PLAY.
6. Abort mid-CHECK: reset_n low during the 5th-placement CHECK → immediate START and all reset values. Then center in WIN/LOSE → INIT, board cleared, move_count=0.
